hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Hazard and forwarding controller that drives the control side of the pipeline registers.
- Generates the ID/EX flush (rst_ID_EX), the IF/ID flush, and the PC/IF-ID write enables.
- Generates the EX-stage forwarding selects.
- Keeps its own shadow copy of the EX/MEM/WB destination fields, so it needs no taps on the datapath registers.
- Sits beside the ID stage; counts stalls and flushes for performance debug.

Parameters:
- MEM_FWD, 1, 1 = load data is forwardable from MEM/WB, so a load-use hazard costs one bubble; 0 = also stall when the MEM-stage load matches (two bubbles).
- CNT_W, 16, width of the saturating stall and flush counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  5  ID source register 1
- id_rt  in  5  ID source register 2
- id_uses_rt  in  1  ID instruction reads rt
- id_dest  in  5  ID destination register (rd or rt, already muxed)
- id_wr  in  1  ID instruction writes the register file
- id_is_load  in  1  ID instruction is lw
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- pc_write  out  1  PC may update
- if_id_write  out  1  IF/ID may load
- rst_IF_ID  out  1  clear IF/ID next edge
- rst_ID_EX  out  1  clear ID/EX next edge (bubble)
- forward_a  out  2  EX operand A select: 00 reg file, 10 EX/MEM, 01 MEM/WB
- forward_b  out  2  EX operand B select, same encoding
- stall_cnt  out  CNT_W  load-use stall cycles, saturating
- flush_cnt  out  CNT_W  branch flush events, saturating

Behaviour:
- Shadow stages: registers for EX (valid, rs, rt, dest, wr, load), MEM (valid, dest, wr, load) and WB (valid, dest, wr), all zero on reset.
- Every edge, MEM <= EX and WB <= MEM.
- EX <= ID fields only if id_valid and there is neither a stall nor a flush; otherwise EX <= bubble (all zero). This mirrors ID/EX being cleared by rst_ID_EX.
- Register-match rule: a comparison counts only if the stage is valid, the stage writes (wr = 1), dest != 0, and, for rt, id_uses_rt = 1.
- hz_ex: EX is a load matching id_rs or id_rt.
- hz_mem: MEM is a load matching id_rs or id_rt, and MEM_FWD = 0.
- stall = id_valid & (hz_ex | hz_mem) & ~ex_branch_taken.
- flush = ex_branch_taken. Flush has priority over stall, because the stalled instruction is on the wrong path.
- Outputs are combinational from the current shadow state and inputs:
  - pc_write = ~stall
  - if_id_write = ~stall
  - rst_IF_ID = flush
  - rst_ID_EX = stall | flush
- On flush, pc_write = 1, so the PC takes the branch target.
- Latency: the stall decision applies in the same cycle. A one-bubble load-use hazard releases on the next cycle because the load moves to MEM.
- Forwarding for operand A (operand B is identical, using ex_rt):
  - 10 if MEM valid & wr & dest != 0 & dest == ex_rs.
  - Else 01 if WB valid & wr & dest != 0 & dest == ex_rs.
  - Else 00.
  - MEM wins when both match.
  - An EX bubble (valid 0) forces 00.
- Counters:
  - stall_cnt increments on each cycle with stall = 1.
  - flush_cnt increments on each cycle with flush = 1.
  - Both saturate at all-ones and never wrap.
- Register $0: never a hazard, never forwarded.
- While rst = 1:
  - pc_write = 0, if_id_write = 0.
  - rst_IF_ID = 1, rst_ID_EX = 1.
  - forward_a/b = 00.
  - All shadows and counters clear at the edge.
- Reset mid-stall: the stall is dropped and there are no leftover bubbles after rst falls.
- Simultaneous stall and flush: the flush outputs apply and stall_cnt does not increment.

Test Plan:
- Directed 1: lw $8 in ID, then add $9,$8,$1 in ID the next cycle → that cycle pc_write=0, if_id_write=0, rst_ID_EX=1, stall_cnt=1; the following cycle pc_write=1, and forward_a=01 when the add reaches EX.
- Directed 2: MEM_FWD=0, same sequence → two consecutive stall cycles, stall_cnt=2.
- Directed 3: ex_branch_taken=1 while the ID instruction load-use matches → rst_IF_ID=1, rst_ID_EX=1, pc_write=1, flush_cnt=1, stall_cnt=0.
- Directed 4: add $3,.. then sub $4,$3,$3 back-to-back → forward_a=forward_b=10. With one unrelated instruction between them → 01. With dest=$0 → 00.
- Directed 5: hold a stall condition for 2^CNT_W+5 cycles with CNT_W=4 → stall_cnt sticks at 15.
- Directed 6: assert rst during a stall → all outputs take their reset values that cycle; after release with no hazard, pc_write=1 and rst_ID_EX=0.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Hazard and forwarding controller beside the ID stage. It keeps shadow copies of the
// EX/MEM/WB destination fields, and it drives the stall, flush and forwarding controls.
module hazard_control_unit #(
    parameter bit MEM_FWD = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_dest,
    input  logic             id_wr,
    input  logic             id_is_load,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             rst_IF_ID,
    output logic             rst_ID_EX,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dest;
        logic       wr;
        logic       load;
    } ex_stage_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       wr;
        logic       load;
    } mem_stage_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       wr;
    } wb_stage_t;

    ex_stage_t        ex_q,  ex_d;
    mem_stage_t       mem_q, mem_d;
    wb_stage_t        wb_q,  wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic     hz_ex;
    logic     hz_mem;
    logic     stall;
    logic     flush;
    fwd_sel_e fwd_a;
    fwd_sel_e fwd_b;

    // A producer only counts when it really writes a nonzero register; $0 is never a hazard.
    function automatic logic reg_match(
        input logic       valid,
        input logic       wr,
        input logic [4:0] dest,
        input logic [4:0] src
    );
        return valid && wr && (dest != 5'd0) && (dest == src);
    endfunction

    function automatic fwd_sel_e fwd_select(
        input logic       ex_valid,
        input logic [4:0] src,
        input mem_stage_t mem_s,
        input wb_stage_t  wb_s
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (ex_valid) begin
            if (reg_match(mem_s.valid, mem_s.wr, mem_s.dest, src)) begin
                sel = FWD_MEM;
            end else if (reg_match(wb_s.valid, wb_s.wr, wb_s.dest, src)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        hz_ex  = 1'b0;
        hz_mem = 1'b0;
        if (ex_q.load) begin
            hz_ex = reg_match(ex_q.valid, ex_q.wr, ex_q.dest, id_rs)
                 || (id_uses_rt && reg_match(ex_q.valid, ex_q.wr, ex_q.dest, id_rt));
        end
        if (!MEM_FWD && mem_q.load) begin
            hz_mem = reg_match(mem_q.valid, mem_q.wr, mem_q.dest, id_rs)
                  || (id_uses_rt && reg_match(mem_q.valid, mem_q.wr, mem_q.dest, id_rt));
        end
        // A taken branch squashes the stalled instruction, so the flush wins.
        flush = ex_branch_taken;
        stall = id_valid && (hz_ex || hz_mem) && !ex_branch_taken;
    end

    always_comb begin
        fwd_a = fwd_select(ex_q.valid, ex_q.rs, mem_q, wb_q);
        fwd_b = fwd_select(ex_q.valid, ex_q.rt, mem_q, wb_q);
    end

    assign pc_write    = !rst && !stall;
    assign if_id_write = !rst && !stall;
    assign rst_IF_ID   = rst || flush;
    assign rst_ID_EX   = rst || stall || flush;
    assign forward_a   = rst ? FWD_RF : fwd_a;
    assign forward_b   = rst ? FWD_RF : fwd_b;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

    always_comb begin
        ex_d = '0;
        if (id_valid && !stall && !flush) begin
            ex_d.valid = 1'b1;
            ex_d.rs    = id_rs;
            ex_d.rt    = id_rt;
            ex_d.dest  = id_dest;
            ex_d.wr    = id_wr;
            ex_d.load  = id_is_load;
        end

        mem_d.valid = ex_q.valid;
        mem_d.dest  = ex_q.dest;
        mem_d.wr    = ex_q.wr;
        mem_d.load  = ex_q.load;

        wb_d.valid = mem_q.valid;
        wb_d.dest  = mem_q.dest;
        wb_d.wr    = mem_q.wr;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        flush_cnt_d = flush_cnt_q;
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all stages advance on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit. Three instances share the ID-side stimulus:
// the default build, one with MEM_FWD=0, and one with 4-bit counters.
module tb_hazard_control_unit;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
        logic [4:0] dst;
        logic       wr;
        logic       ld;
        logic       br;
    } id_t;

    typedef struct {
        id_t         id;
        logic        pc;
        logic        ifid;
        logic        rif;
        logic        rex;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] sc;
        logic [15:0] fc;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] id_dest;
    logic       id_wr;
    logic       id_is_load;
    logic       ex_branch_taken;

    logic        d_pc, d_ifid, d_rif, d_rex;
    logic [1:0]  d_fa, d_fb;
    logic [15:0] d_sc, d_fc;
    logic        n_pc, n_ifid, n_rif, n_rex;
    logic [1:0]  n_fa, n_fb;
    logic [15:0] n_sc, n_fc;
    logic        s_pc, s_ifid, s_rif, s_rex;
    logic [1:0]  s_fa, s_fb;
    logic [3:0]  s_sc, s_fc;

    int total = 0;
    int bad   = 0;

    vec_t vecs[19];

    hazard_control_unit u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_wr(id_wr), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .pc_write(d_pc), .if_id_write(d_ifid),
        .rst_IF_ID(d_rif), .rst_ID_EX(d_rex), .forward_a(d_fa), .forward_b(d_fb),
        .stall_cnt(d_sc), .flush_cnt(d_fc)
    );

    hazard_control_unit #(.MEM_FWD(1'b0), .CNT_W(16)) u_nofwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_wr(id_wr), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .pc_write(n_pc), .if_id_write(n_ifid),
        .rst_IF_ID(n_rif), .rst_ID_EX(n_rex), .forward_a(n_fa), .forward_b(n_fb),
        .stall_cnt(n_sc), .flush_cnt(n_fc)
    );

    hazard_control_unit #(.MEM_FWD(1'b1), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_wr(id_wr), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .pc_write(s_pc), .if_id_write(s_ifid),
        .rst_IF_ID(s_rif), .rst_ID_EX(s_rex), .forward_a(s_fa), .forward_b(s_fb),
        .stall_cnt(s_sc), .flush_cnt(s_fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_id(input id_t x);
        id_valid        = x.v;
        id_rs           = x.rs;
        id_rt           = x.rt;
        id_uses_rt      = x.ur;
        id_dest         = x.dst;
        id_wr           = x.wr;
        id_is_load      = x.ld;
        ex_branch_taken = x.br;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " pc_write"},    32'(d_pc),   32'd0);
        check({tag, " if_id_write"}, 32'(d_ifid), 32'd0);
        check({tag, " rst_IF_ID"},   32'(d_rif),  32'd1);
        check({tag, " rst_ID_EX"},   32'(d_rex),  32'd1);
        check({tag, " forward_a"},   32'(d_fa),   32'd0);
        check({tag, " forward_b"},   32'(d_fb),   32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        apply_id('0);
        @(negedge clk);
        check_reset_outputs(tag);
        next_cycle();
        rst = 1'b0;
    endtask

    localparam id_t IDLE    = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
    localparam id_t LW8     = '{1'b1, 5'd2, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0};
    localparam id_t ADD981  = '{1'b1, 5'd8, 5'd1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0};
    localparam id_t LW8_8   = '{1'b1, 5'd8, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0};
    localparam id_t ADD3    = '{1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0};
    localparam id_t SUB433  = '{1'b1, 5'd3, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0};
    localparam id_t ADD211  = '{1'b1, 5'd1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0};
    localparam id_t ADD982  = '{1'b1, 5'd8, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0};

    initial begin
        id_t tmp;
        rst = 1'b1;
        apply_id(IDLE);

        // Continuous pipeline run on the default build: {id}, pc, ifid, rIF, rEX, fa, fb, stall_cnt, flush_cnt
        vecs[0]  = '{'{1'b1, 5'd2,  5'd8,  1'b0, 5'd8,  1'b1, 1'b1, 1'b0}, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0};
        vecs[1]  = '{'{1'b1, 5'd8,  5'd1,  1'b1, 5'd9,  1'b1, 1'b0, 1'b0}, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 16'd0, 16'd0};
        vecs[2]  = '{'{1'b1, 5'd8,  5'd1,  1'b1, 5'd9,  1'b1, 1'b0, 1'b0}, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'd1, 16'd0};
        vecs[3]  = '{'{1'b1, 5'd9,  5'd9,  1'b1, 5'd4,  1'b1, 1'b0, 1'b0}, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 16'd1, 16'd0};
        vecs[4]  = '{'{1'b1, 5'd1,  5'd2,  1'b1, 5'd5,  1'b1, 1'b0, 1'b0}, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 16'd1, 16'd0};
        vecs[5]  = '{'{1'b1, 5'd9,  5'd4,  1'b1, 5'd6,  1'b1, 1'b0, 1'b0}, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'd1, 16'd0};
        vecs[6]  = '{'{1'b1, 5'd1,  5'd1,  1'b1, 5'd0,  1'b1, 1'b0, 1'b0}, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 16'd1, 16'd0};
        vecs[7]  = '{'{1'b1, 5'd0,  5'd0,  1'b1, 5'd7,  1'b1, 1'b0, 1'b0}, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'd1, 16'd0};
        vecs[8]  = '{'{1'b1, 5'd3,  5'd0,  1'b0, 5'd0,  1'b1, 1'b1, 1'b0}, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'd1, 16'd0};
        vecs[9]  = '{'{1'b1, 5'd0,  5'd0,  1'b1, 5'd10, 1'b1, 1'b0, 1'b0}, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'd1, 16'd0};
        vecs[10] = '{'{1'b1, 5'd3,  5'd11, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0}, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'd1, 16'd0};
        vecs[11] = '{'{1'b1, 5'd1,  5'd11, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0}, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 16'd1, 16'd0};
        vecs[12] = '{'{1'b1, 5'd1,  5'd11, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0}, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'd2, 16'd0};
        vecs[13] = '{'{1'b1, 5'd2,  5'd13, 1'b0, 5'd13, 1'b1, 1'b1, 1'b0}, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 16'd2, 16'd0};
        vecs[14] = '{'{1'b1, 5'd2,  5'd13, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0}, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'd2, 16'd0};
        vecs[15] = '{'{1'b1, 5'd1,  5'd1,  1'b1, 5'd1,  1'b1, 1'b0, 1'b1}, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b10, 16'd2, 16'd0};
        vecs[16] = '{'{1'b1, 5'd0,  5'd15, 1'b0, 5'd15, 1'b1, 1'b1, 1'b0}, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'd2, 16'd1};
        vecs[17] = '{'{1'b0, 5'd15, 5'd15, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0}, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'd2, 16'd1};
        vecs[18] = '{'{1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0}, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'd2, 16'd1};

        do_reset("init");
        check("init stall_cnt", 32'(d_sc), 32'd0);
        check("init flush_cnt", 32'(d_fc), 32'd0);

        for (int i = 0; i < 19; i++) begin
            apply_id(vecs[i].id);
            @(negedge clk);
            check($sformatf("row%0d pc_write", i),    32'(d_pc),   32'(vecs[i].pc));
            check($sformatf("row%0d if_id_write", i), 32'(d_ifid), 32'(vecs[i].ifid));
            check($sformatf("row%0d rst_IF_ID", i),   32'(d_rif),  32'(vecs[i].rif));
            check($sformatf("row%0d rst_ID_EX", i),   32'(d_rex),  32'(vecs[i].rex));
            check($sformatf("row%0d forward_a", i),   32'(d_fa),   32'(vecs[i].fa));
            check($sformatf("row%0d forward_b", i),   32'(d_fb),   32'(vecs[i].fb));
            check($sformatf("row%0d stall_cnt", i),   32'(d_sc),   32'(vecs[i].sc));
            check($sformatf("row%0d flush_cnt", i),   32'(d_fc),   32'(vecs[i].fc));
            next_cycle();
        end

        // Load-use: one bubble with MEM forwarding, two without.
        do_reset("lu");
        check("lu stall_cnt cleared", 32'(d_sc), 32'd0);
        apply_id(LW8);
        @(negedge clk);
        check("lu nofwd lw pc_write", 32'(n_pc), 32'd1);
        next_cycle();
        apply_id(ADD981);
        @(negedge clk);
        check("lu dut stall pc_write",      32'(d_pc),   32'd0);
        check("lu dut stall if_id_write",   32'(d_ifid), 32'd0);
        check("lu dut stall rst_ID_EX",     32'(d_rex),  32'd1);
        check("lu nofwd stall1 pc_write",   32'(n_pc),   32'd0);
        next_cycle();
        @(negedge clk);
        check("lu dut release pc_write",    32'(d_pc),   32'd1);
        check("lu dut release rst_ID_EX",   32'(d_rex),  32'd0);
        check("lu dut stall_cnt",           32'(d_sc),   32'd1);
        check("lu nofwd stall2 pc_write",   32'(n_pc),   32'd0);
        check("lu nofwd stall2 if_id_write", 32'(n_ifid), 32'd0);
        check("lu nofwd stall2 rst_ID_EX",  32'(n_rex),  32'd1);
        next_cycle();
        @(negedge clk);
        check("lu dut add in EX forward_a", 32'(d_fa),   32'd1);
        check("lu nofwd release pc_write",  32'(n_pc),   32'd1);
        check("lu nofwd stall_cnt",         32'(n_sc),   32'd2);
        check("lu dut stall_cnt held",      32'(d_sc),   32'd1);
        next_cycle();

        // Branch taken while the ID instruction load-use matches: flush wins.
        do_reset("br");
        apply_id(LW8);
        next_cycle();
        tmp = ADD981;
        tmp.br = 1'b1;
        apply_id(tmp);
        @(negedge clk);
        check("br rst_IF_ID",   32'(d_rif),  32'd1);
        check("br rst_ID_EX",   32'(d_rex),  32'd1);
        check("br pc_write",    32'(d_pc),   32'd1);
        check("br if_id_write", 32'(d_ifid), 32'd1);
        next_cycle();
        apply_id(IDLE);
        @(negedge clk);
        check("br flush_cnt", 32'(d_fc), 32'd1);
        check("br stall_cnt", 32'(d_sc), 32'd0);
        next_cycle();

        // Back-to-back writers of $3: the younger one in MEM wins over WB.
        do_reset("fwd");
        apply_id(ADD3);
        next_cycle();
        apply_id(ADD3);
        next_cycle();
        apply_id(SUB433);
        next_cycle();
        apply_id(IDLE);
        @(negedge clk);
        check("fwd prio forward_a", 32'(d_fa), 32'd2);
        check("fwd prio forward_b", 32'(d_fb), 32'd2);
        next_cycle();
        @(negedge clk);
        check("fwd bubble forward_a", 32'(d_fa), 32'd0);
        check("fwd bubble forward_b", 32'(d_fb), 32'd0);
        next_cycle();

        // 4-bit counters saturate at 15 instead of wrapping.
        do_reset("sat");
        apply_id(LW8_8);
        for (int k = 0; k < 42; k++) begin
            next_cycle();
        end
        @(negedge clk);
        check("sat stall_cnt", 32'(s_sc), 32'd15);
        next_cycle();
        tmp = LW8_8;
        tmp.br = 1'b1;
        apply_id(tmp);
        for (int k = 0; k < 21; k++) begin
            next_cycle();
        end
        @(negedge clk);
        check("sat flush_cnt",      32'(s_fc), 32'd15);
        check("sat stall_cnt held", 32'(s_sc), 32'd15);
        next_cycle();

        // Reset raised in the middle of a stall cycle.
        do_reset("rs");
        apply_id(ADD211);
        next_cycle();
        apply_id(LW8);
        next_cycle();
        apply_id(ADD982);
        @(negedge clk);
        check("rs stall pc_write",  32'(d_pc), 32'd0);
        check("rs stall forward_a", 32'(d_fa), 32'd2);
        rst = 1'b1;
        #1;
        check_reset_outputs("rs during");
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rs after pc_write",  32'(d_pc),  32'd1);
        check("rs after rst_ID_EX", 32'(d_rex), 32'd0);
        check("rs after forward_a", 32'(d_fa),  32'd0);
        check("rs after stall_cnt", 32'(d_sc),  32'd0);
        next_cycle();
        @(negedge clk);
        check("rs later pc_write",  32'(d_pc),  32'd1);
        check("rs later rst_ID_EX", 32'(d_rex), 32'd0);
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
